// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
//  Shared definitions for the IF/ID sequencing logic:
//   - the opcodes that read rs1/rs2 (OP_R, OP_IMM, OP_LD, OP_SD, OP_BEQ)
//   - the NOP encoding that IF/ID loads on a flush (addi x0,x0,0)
//   - the hazard controller state enum
//   - helpers that decide which source registers an opcode reads
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        HS_RUN        = 2'd0,
        HS_LOAD_STALL = 2'd1
    } hazard_state_t;

    // rs2 is a real register read only for R-type, stores and branches;
    // for I-type formats those bits are immediate and must not match.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_SD) || (opcode == OP_BEQ);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return uses_rs2(opcode) || (opcode == OP_IMM) || (opcode == OP_LD);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
//  Purely combinational load-use hazard detector.
//  Ports:
//   ifid_opcode   in  7  opcode of the instruction in IF/ID
//   ifid_rs1      in  5  rs1 field of the IF/ID instruction
//   ifid_rs2      in  5  rs2 field of the IF/ID instruction
//   idex_mem_read in  1  ID/EX instruction is a load
//   idex_rd       in  5  destination register of the ID/EX instruction
//   hz            out 1  IF/ID instruction reads the register being loaded
// -----------------------------------------------------------------------------
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [6:0] ifid_opcode,
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rd,
    output logic       hz
);

    logic use_rs1;
    logic use_rs2;
    logic match_rs1;
    logic match_rs2;

    assign use_rs1   = uses_rs1(ifid_opcode);
    assign use_rs2   = uses_rs2(ifid_opcode);
    assign match_rs1 = use_rs1 && (idex_rd == ifid_rs1);
    assign match_rs2 = use_rs2 && (idex_rd == ifid_rs2);

    // x0 is hardwired to zero, so a load into it never creates a dependency.
    assign hz = idex_mem_read && (idex_rd != 5'd0) && (match_rs1 || match_rs2);

endmodule

// File: rtl/ifid_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// ifid_hazard_ctrl
//  Sequencing controller for the PC and IF/ID register. Stalls PC and IF/ID
//  for LOAD_LAT cycles on a load-use hazard while bubbling ID/EX, and flushes
//  IF/ID when a taken branch resolves in EX. Keeps saturating counters of
//  stalled and flushed cycles.
//  Parameters:
//   LOAD_LAT  stall cycles per load-use hazard (>=1)
//   CNT_W     width of the performance counters
//  Ports:
//   clk, reset        clock, async active-high reset
//   ifid_opcode/rs1/rs2, idex_mem_read, idex_rd   hazard detection inputs
//   ex_branch_taken   taken branch resolved in EX this cycle
//   pc_write          PC may update
//   ifid_write        IF/ID captures a new instruction
//   ifid_flush        IF/ID loads a NOP at the next edge
//   idex_bubble       ID/EX control fields are zeroed at the next edge
//   pc_src_branch     PC mux selects the branch target
//   hazard_state      0 RUN, 1 LOAD_STALL
//   stall_count       cycles with pc_write low (saturating)
//   flush_count       cycles with ifid_flush high (saturating)
// -----------------------------------------------------------------------------
module ifid_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       ifid_opcode,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pc_src_branch,
    output logic [1:0]       hazard_state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int REM_W = $clog2(LOAD_LAT) + 1;

    hazard_state_t    state_reg;
    hazard_state_t    state_next;
    logic [REM_W-1:0] rem_reg;
    logic [REM_W-1:0] rem_next;
    logic [CNT_W-1:0] stall_count_reg;
    logic [CNT_W-1:0] flush_count_reg;
    logic             hz;
    logic             stall_now;
    logic             flush_now;

    load_use_detect u_detect (
        .ifid_opcode   (ifid_opcode),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .hz            (hz)
    );

    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        pc_src_branch = 1'b0;
        stall_now     = 1'b0;
        flush_now     = 1'b0;
        state_next    = state_reg;
        rem_next      = rem_reg;

        if (ex_branch_taken) begin
            // A taken branch squashes both the fetched instruction and
            // whatever is waiting in ID, so any pending load stall is moot.
            pc_src_branch = 1'b1;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            flush_now     = 1'b1;
            state_next    = HS_RUN;
            rem_next      = '0;
        end else if (state_reg == HS_LOAD_STALL) begin
            // hz is not re-checked here: the load is already past ID/EX.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_now   = 1'b1;
            rem_next    = rem_reg - REM_W'(1);
            if (rem_reg == REM_W'(1)) begin
                state_next = HS_RUN;
            end
        end else if (hz) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_now   = 1'b1;
            if (LOAD_LAT > 1) begin
                state_next = HS_LOAD_STALL;
                rem_next   = REM_W'(LOAD_LAT - 1);
            end
        end

        // Held in reset the pipeline is frozen and filled with NOPs/bubbles.
        if (reset) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            pc_src_branch = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= HS_RUN;
            rem_reg         <= '0;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            if (stall_now && (stall_count_reg != {CNT_W{1'b1}})) begin
                stall_count_reg <= stall_count_reg + CNT_W'(1);
            end
            if (flush_now && (flush_count_reg != {CNT_W{1'b1}})) begin
                flush_count_reg <= flush_count_reg + CNT_W'(1);
            end
        end
    end

    assign hazard_state = state_reg;
    assign stall_count  = stall_count_reg;
    assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ifid_hazard_ctrl
//  Three controller instances share one stimulus stream:
//   u_l1  LOAD_LAT=1, CNT_W=16
//   u_l3  LOAD_LAT=3, CNT_W=16
//   u_sat LOAD_LAT=1, CNT_W=2
//  Inputs change on the falling edge; outputs are sampled 1ns later or on the
//  following falling edge, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_ifid_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic [6:0] ifid_opcode;
    logic [4:0] ifid_rs1;
    logic [4:0] ifid_rs2;
    logic       idex_mem_read;
    logic [4:0] idex_rd;
    logic       ex_branch_taken;

    logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_pc_src_branch;
    logic [1:0]  a_hazard_state;
    logic [15:0] a_stall_count, a_flush_count;

    logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_pc_src_branch;
    logic [1:0]  b_hazard_state;
    logic [15:0] b_stall_count, b_flush_count;

    logic        c_pc_write, c_ifid_write, c_ifid_flush, c_idex_bubble, c_pc_src_branch;
    logic [1:0]  c_hazard_state;
    logic [1:0]  c_stall_count, c_flush_count;

    int checks = 0;
    int errors = 0;

    ifid_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u_l1 (
        .clk(clk), .reset(reset), .ifid_opcode(ifid_opcode), .ifid_rs1(ifid_rs1),
        .ifid_rs2(ifid_rs2), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ex_branch_taken(ex_branch_taken), .pc_write(a_pc_write), .ifid_write(a_ifid_write),
        .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble), .pc_src_branch(a_pc_src_branch),
        .hazard_state(a_hazard_state), .stall_count(a_stall_count), .flush_count(a_flush_count)
    );

    ifid_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u_l3 (
        .clk(clk), .reset(reset), .ifid_opcode(ifid_opcode), .ifid_rs1(ifid_rs1),
        .ifid_rs2(ifid_rs2), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ex_branch_taken(ex_branch_taken), .pc_write(b_pc_write), .ifid_write(b_ifid_write),
        .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble), .pc_src_branch(b_pc_src_branch),
        .hazard_state(b_hazard_state), .stall_count(b_stall_count), .flush_count(b_flush_count)
    );

    ifid_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .ifid_opcode(ifid_opcode), .ifid_rs1(ifid_rs1),
        .ifid_rs2(ifid_rs2), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ex_branch_taken(ex_branch_taken), .pc_write(c_pc_write), .ifid_write(c_ifid_write),
        .ifid_flush(c_ifid_flush), .idex_bubble(c_idex_bubble), .pc_src_branch(c_pc_src_branch),
        .hazard_state(c_hazard_state), .stall_count(c_stall_count), .flush_count(c_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic mr, input logic [4:0] rd, input logic br);
        ifid_opcode     = op;
        ifid_rs1        = rs1;
        ifid_rs2        = rs2;
        idex_mem_read   = mr;
        idex_rd         = rd;
        ex_branch_taken = br;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Reset asserted while u_l3 is in LOAD_STALL.
    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (b_pc_write !== 1'b1 || b_hazard_state !== 2'd0 || b_stall_count !== 16'd0) begin
            errors++; $display("FAIL reset_idle: pc_write=%b state=%0d stall=%0d, want 1 0 0", b_pc_write, b_hazard_state, b_stall_count); end
        @(negedge clk);
        drive(OP_SD, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0);
        @(negedge clk);
        drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        checks++; if (b_hazard_state !== 2'd1 || b_stall_count !== 16'd1) begin
            errors++; $display("FAIL reset_pre_stall: state=%0d stall=%0d, want 1 1", b_hazard_state, b_stall_count); end
        reset = 1'b1;
        #1;
        checks++; if (b_hazard_state !== 2'd0 || b_stall_count !== 16'd0 || b_flush_count !== 16'd0) begin
            errors++; $display("FAIL reset_async: state=%0d stall=%0d flush=%0d, want 0 0 0", b_hazard_state, b_stall_count, b_flush_count); end
        checks++; if ({b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_pc_src_branch} !== 5'b00110) begin
            errors++; $display("FAIL reset_outputs: got %b want 00110", {b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_pc_src_branch}); end
        @(posedge clk); #1;
        checks++; if (b_hazard_state !== 2'd0 || b_stall_count !== 16'd0 || b_ifid_flush !== 1'b1 || b_idex_bubble !== 1'b1) begin
            errors++; $display("FAIL reset_held: state=%0d stall=%0d flush=%b bubble=%b, want 0 0 1 1", b_hazard_state, b_stall_count, b_ifid_flush, b_idex_bubble); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if ({b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble} !== 4'b1100 || b_hazard_state !== 2'd0) begin
            errors++; $display("FAIL reset_release: outs=%b state=%0d, want 1100 0", {b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble}, b_hazard_state); end
        $display("test_reset done");
    endtask

    // Single-cycle load-use stall on rs1 (LOAD_LAT=1).
    task automatic test_load_use_rs1();
        do_reset();
        drive(OP_R, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0);
        #1;
        checks++; if ({a_pc_write, a_ifid_write, a_idex_bubble, a_ifid_flush} !== 4'b0010) begin
            errors++; $display("FAIL rs1_stall: pc_w/ifid_w/bubble/flush=%b want 0010", {a_pc_write, a_ifid_write, a_idex_bubble, a_ifid_flush}); end
        @(negedge clk);
        drive(OP_R, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);   // bubble now sits in ID/EX
        #1;
        checks++; if (a_pc_write !== 1'b1 || a_idex_bubble !== 1'b0 || a_stall_count !== 16'd1) begin
            errors++; $display("FAIL rs1_release: pc_write=%b bubble=%b stall=%0d, want 1 0 1", a_pc_write, a_idex_bubble, a_stall_count); end
        @(negedge clk);
        checks++; if (a_stall_count !== 16'd1 || a_hazard_state !== 2'd0) begin
            errors++; $display("FAIL rs1_count: stall=%0d state=%0d, want 1 0", a_stall_count, a_hazard_state); end
        $display("test_load_use_rs1 done");
    endtask

    // Register fields that are not real reads must not stall.
    task automatic test_no_false_hazard();
        do_reset();
        drive(OP_IMM, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0);
        #1;
        checks++; if (a_pc_write !== 1'b1 || a_idex_bubble !== 1'b0) begin
            errors++; $display("FAIL nofalse_imm_rs2: pc_write=%b bubble=%b, want 1 0", a_pc_write, a_idex_bubble); end
        @(negedge clk);
        drive(OP_R, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        #1;
        checks++; if (a_pc_write !== 1'b1 || a_idex_bubble !== 1'b0) begin
            errors++; $display("FAIL nofalse_x0: pc_write=%b bubble=%b, want 1 0", a_pc_write, a_idex_bubble); end
        @(negedge clk);
        drive(7'b0110111, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0);   // LUI reads no register
        #1;
        checks++; if (a_pc_write !== 1'b1) begin
            errors++; $display("FAIL nofalse_lui: pc_write=%b, want 1", a_pc_write); end
        @(negedge clk);
        drive(OP_LD, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0);        // load-after-load on rs1
        #1;
        checks++; if (a_pc_write !== 1'b0) begin
            errors++; $display("FAIL ld_rs1_hazard: pc_write=%b, want 0", a_pc_write); end
        @(negedge clk);
        drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        checks++; if (a_stall_count !== 16'd1) begin
            errors++; $display("FAIL nofalse_count: stall=%0d, want 1", a_stall_count); end
        $display("test_no_false_hazard done");
    endtask

    // LOAD_LAT=3 stall driven by an sd whose rs2 matches the load.
    task automatic test_multi_cycle_stall();
        logic [1:0] exp_state [4];
        logic       exp_pcw   [4];
        exp_state[0] = 2'd0; exp_state[1] = 2'd1; exp_state[2] = 2'd1; exp_state[3] = 2'd0;
        exp_pcw[0]   = 1'b0; exp_pcw[1]   = 1'b0; exp_pcw[2]   = 1'b0; exp_pcw[3]   = 1'b1;
        do_reset();
        drive(OP_SD, 5'd2, 5'd12, 1'b1, 5'd12, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (b_hazard_state !== exp_state[i] || b_pc_write !== exp_pcw[i] || b_idex_bubble !== ~exp_pcw[i]) begin
                errors++; $display("FAIL multi_cyc%0d: state=%0d pc_write=%b bubble=%b, want %0d %b %b",
                                   i, b_hazard_state, b_pc_write, b_idex_bubble, exp_state[i], exp_pcw[i], ~exp_pcw[i]); end
            @(negedge clk);
            drive(OP_SD, 5'd2, 5'd12, 1'b0, 5'd0, 1'b0);   // load gone; stall must persist anyway
        end
        checks++; if (b_stall_count !== 16'd3 || b_hazard_state !== 2'd0) begin
            errors++; $display("FAIL multi_count: stall=%0d state=%0d, want 3 0", b_stall_count, b_hazard_state); end
        $display("test_multi_cycle_stall done");
    endtask

    // Branch in the 2nd stall cycle aborts LOAD_STALL.
    task automatic test_branch_abort();
        do_reset();
        drive(OP_BEQ, 5'd4, 5'd8, 1'b1, 5'd8, 1'b0);
        @(negedge clk);
        drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        #1;
        checks++; if (b_hazard_state !== 2'd1) begin
            errors++; $display("FAIL abort_pre: state=%0d, want 1", b_hazard_state); end
        checks++; if ({b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_pc_src_branch} !== 5'b11111) begin
            errors++; $display("FAIL abort_outs: got %b want 11111", {b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_pc_src_branch}); end
        @(negedge clk);
        drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        checks++; if (b_hazard_state !== 2'd0 || b_pc_write !== 1'b1 || b_ifid_flush !== 1'b0) begin
            errors++; $display("FAIL abort_run: state=%0d pc_write=%b flush=%b, want 0 1 0", b_hazard_state, b_pc_write, b_ifid_flush); end
        checks++; if (b_stall_count !== 16'd1 || b_flush_count !== 16'd1) begin
            errors++; $display("FAIL abort_counts: stall=%0d flush=%0d, want 1 1", b_stall_count, b_flush_count); end
        $display("test_branch_abort done");
    endtask

    // Hazard and branch in the same cycle: branch wins, no stall counted.
    task automatic test_back_to_back();
        do_reset();
        drive(OP_R, 5'd6, 5'd6, 1'b1, 5'd6, 1'b1);
        #1;
        checks++; if ({a_pc_write, a_ifid_flush, a_pc_src_branch} !== 3'b111) begin
            errors++; $display("FAIL hz_br_outs: pc_w/flush/src=%b want 111", {a_pc_write, a_ifid_flush, a_pc_src_branch}); end
        @(negedge clk);
        drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        checks++; if (a_stall_count !== 16'd0 || a_flush_count !== 16'd2) begin
            errors++; $display("FAIL hz_br_counts: stall=%0d flush=%0d, want 0 2", a_stall_count, a_flush_count); end
        $display("test_back_to_back done");
    endtask

    // 2-bit counter must stop at 3.
    task automatic test_saturation();
        do_reset();
        drive(OP_R, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++; if (c_stall_count !== ((i > 3) ? 2'd3 : 2'(i)) || c_pc_write !== 1'b0) begin
                errors++; $display("FAIL sat_cyc%0d: stall=%0d pc_write=%b, want %0d 0",
                                   i, c_stall_count, c_pc_write, (i > 3) ? 3 : i); end
        end
        drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        $display("test_saturation done");
    endtask

    initial begin
        reset = 1'b1;
        drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        test_reset();
        test_load_use_rs1();
        test_no_false_hazard();
        test_multi_cycle_stall();
        test_branch_abort();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
